// File: rtl/gate_array_pipe.sv
// Array of CHANNELS two-input bitwise gates behind a 2-entry in-order valid/ready buffer.
// Optional 16-bit release counter txn_count is enabled by defining GATE_ARRAY_PIPE_STATS_EN.
module gate_array_pipe #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                op,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] y,
  output logic [CHANNELS-1:0]       y_zero
`ifdef GATE_ARRAY_PIPE_STATS_EN
  ,
  output logic [15:0]               txn_count
`endif
);

  localparam int unsigned DW = CHANNELS * WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  logic [DW-1:0]       tail_y;
  logic [DW-1:0]       res_c;
  logic [CHANNELS-1:0] res_zero_c;
  logic [CHANNELS-1:0] tail_zero_c;
  logic                do_accept_c;
  logic                do_release_c;

  assign do_accept_c  = in_valid && in_ready;
  assign do_release_c = out_valid && out_ready;

  // Gate function, applied bitwise across all channels at once
  always_comb begin
    res_c = '0;
    case (op)
      3'd0: res_c = a & b;
      3'd1: res_c = a | b;
      3'd2: res_c = a ^ b;
      3'd3: res_c = ~(a & b);
      3'd4: res_c = ~(a | b);
      3'd5: res_c = ~(a ^ b);
      3'd6: res_c = a;
      3'd7: res_c = ~a;
      default: res_c = '0;
    endcase
  end

  // Per-channel all-zero flags for the fresh result and the queued tail entry
  always_comb begin
    res_zero_c  = '0;
    tail_zero_c = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      res_zero_c[k]  = (res_c[k*WIDTH +: WIDTH] == '0);
      tail_zero_c[k] = (tail_y[k*WIDTH +: WIDTH] == '0);
    end
  end

  // Head entry lives directly in y/y_zero so the outputs are registered and zero when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      y_zero    <= '0;
      tail_y    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (do_accept_c) begin
            y         <= res_c;
            y_zero    <= res_zero_c;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (do_accept_c && do_release_c) begin
            y      <= res_c;
            y_zero <= res_zero_c;
          end else if (do_accept_c) begin
            tail_y   <= res_c;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (do_release_c) begin
            y         <= '0;
            y_zero    <= '0;
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (do_release_c) begin
            y        <= tail_y;
            y_zero   <= tail_zero_c;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          y         <= '0;
          y_zero    <= '0;
        end
      endcase
    end
  end

`ifdef GATE_ARRAY_PIPE_STATS_EN
  // Saturating count of released results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count <= 16'h0000;
    end else if (do_release_c && (txn_count != 16'hFFFF)) begin
      txn_count <= txn_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_array_pipe.sv
// Self-checking bench for gate_array_pipe: directed scenarios plus randomized traffic against a queue model.
// Define GATE_ARRAY_PIPE_STATS_EN to also check txn_count.
module tb_gate_array_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] op;
  logic [3:0] a, b, y;
  logic [3:0] y_zero;
`ifdef GATE_ARRAY_PIPE_STATS_EN
  logic [15:0] txn_count;
`endif

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [2:0]  w_op;
  logic [23:0] w_a, w_b, w_y;
  logic [2:0]  w_y_zero;
`ifdef GATE_ARRAY_PIPE_STATS_EN
  logic [15:0] w_txn_count;
`endif

  int checks = 0;
  int errors = 0;
  int releases = 0;
  logic [3:0] q[$];

  gate_array_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_zero(y_zero)
`ifdef GATE_ARRAY_PIPE_STATS_EN
    , .txn_count(txn_count)
`endif
  );

  gate_array_pipe #(.CHANNELS(3), .WIDTH(8)) dut_wide (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op), .a(w_a), .b(w_b),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .y(w_y), .y_zero(w_y_zero)
`ifdef GATE_ARRAY_PIPE_STATS_EN
    , .txn_count(w_txn_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel-by-channel truth of the eight gate functions
  function automatic logic [3:0] ref_y(input logic [2:0] f, input logic [3:0] x, input logic [3:0] z);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      case (f)
        3'd0: r[k] = x[k] & z[k];
        3'd1: r[k] = x[k] | z[k];
        3'd2: r[k] = x[k] ^ z[k];
        3'd3: r[k] = !(x[k] & z[k]);
        3'd4: r[k] = !(x[k] | z[k]);
        3'd5: r[k] = (x[k] == z[k]);
        3'd6: r[k] = x[k];
        default: r[k] = !x[k];
      endcase
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_zero(input logic [3:0] v);
    logic [3:0] zf;
    for (int k = 0; k < 4; k++) zf[k] = (v[k] == 1'b0);
    return zf;
  endfunction

  function automatic logic [3:0] head_y();
    return (q.size() != 0) ? q[0] : 4'h0;
  endfunction

  // One clock of traffic; the queue model decides accept/release from its own occupancy
  task automatic step();
    bit acc, rel;
    logic [3:0] r;
    acc = in_valid && (q.size() < 2);
    rel = out_ready && (q.size() != 0);
    r   = ref_y(op, a, b);
    @(posedge clk);
    #1;
    if (rel) begin
      void'(q.pop_front());
      releases++;
    end
    if (acc) q.push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    q.delete();
    releases = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 0; op = 0; a = 0; b = 0;
    w_in_valid = 0; w_out_ready = 0; w_op = 0; w_a = 0; w_b = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 4'h0 || y_zero !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b y=%h yz=%h, expected rdy=1 vld=0 y=0 yz=0",
               in_ready, out_valid, y, y_zero);
    end
`ifdef GATE_ARRAY_PIPE_STATS_EN
    checks++;
    if (txn_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_txn_count: got %0d expected 0", txn_count);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_ops();
    logic [3:0] tbl [8];
    tbl = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100, 4'b0011};
    for (int f = 0; f < 8; f++) begin
      in_valid = 1; out_ready = 1; op = 3'(f); a = 4'b1100; b = 4'b1010;
      step();
      checks++;
      if (out_valid !== 1'b1 || y !== tbl[f] || y_zero !== ~tbl[f]) begin
        errors++;
        $display("FAIL op_%0d: got vld=%b y=%b yz=%b, expected vld=1 y=%b yz=%b",
                 f, out_valid, y, y_zero, tbl[f], ~tbl[f]);
      end
      in_valid = 0;
      step();
      checks++;
      if (out_valid !== 1'b0 || y !== 4'h0 || y_zero !== 4'h0) begin
        errors++;
        $display("FAIL op_%0d_drain: got vld=%b y=%b yz=%b, expected 0 0 0", f, out_valid, y, y_zero);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] first;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; op = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
      if (i > 2) in_valid = 0;
      step();
      if (i == 0) first = head_y();
      checks++;
      if (in_ready !== (i == 0) || out_valid !== 1'b1 || y !== first || y_zero !== ref_zero(first)) begin
        errors++;
        $display("FAIL stall_%0d: got rdy=%b vld=%b y=%h, expected rdy=%b vld=1 y=%h",
                 i, in_ready, out_valid, y, (i == 0), first);
      end
    end
    checks++;
    if (q.size() != 2) begin
      errors++;
      $display("FAIL stall_model_depth: got %0d expected 2", q.size());
    end
    // Re-offer a third request while draining; it enters once a slot has been freed
    out_ready = 1; in_valid = 1; op = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) in_valid = 0;
      step();
      checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) || y !== head_y()) begin
        errors++;
        $display("FAIL drain_%0d: got vld=%b rdy=%b y=%h, expected vld=%b rdy=%b y=%h",
                 i, out_valid, in_ready, y, (q.size() != 0), (q.size() < 2), head_y());
      end
    end
  endtask

  task automatic test_throughput();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; op = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || y !== head_y() || y_zero !== ref_zero(head_y())) begin
        errors++;
        $display("FAIL tput_%0d: got vld=%b rdy=%b y=%h, expected vld=1 rdy=1 y=%h",
                 i, out_valid, in_ready, y, head_y());
      end
    end
    in_valid = 0;
    step();
    checks++;
    if (out_valid !== 1'b0 || releases != 10) begin
      errors++;
      $display("FAIL tput_end: got vld=%b releases=%0d, expected vld=0 releases=10", out_valid, releases);
    end
`ifdef GATE_ARRAY_PIPE_STATS_EN
    checks++;
    if (txn_count !== 16'd10) begin
      errors++;
      $display("FAIL tput_txn_count: got %0d expected 10", txn_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; op = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
      step();
    end
    in_valid = 0;
    #3 rst = 1'b1;
    #1;
    q.delete();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 4'h0 || y_zero !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b vld=%b y=%h yz=%h, expected rdy=1 vld=0 y=0 yz=0",
               in_ready, out_valid, y, y_zero);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || y !== 4'h0) begin
        errors++;
        $display("FAIL reset_stale_%0d: got vld=%b y=%h, expected vld=0 y=0", i, out_valid, y);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
      step();
      checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) ||
          y !== head_y() || y_zero !== ((q.size() != 0) ? ref_zero(head_y()) : 4'h0)) begin
        errors++;
        $display("FAIL random_%0d: got vld=%b rdy=%b y=%h yz=%h, expected vld=%b rdy=%b y=%h",
                 i, out_valid, in_ready, y, y_zero, (q.size() != 0), (q.size() < 2), head_y());
      end
    end
    in_valid = 0; out_ready = 1;
    step();
    step();
  endtask

  task automatic test_wide();
    w_in_valid = 1; w_out_ready = 1; w_op = 3'd2; w_a = 24'hFF00AA; w_b = 24'hFF0055;
    @(posedge clk);
    #1;
    w_in_valid = 0;
    checks++;
    if (w_out_valid !== 1'b1 || w_y !== 24'h0000FF || w_y_zero !== 3'b110) begin
      errors++;
      $display("FAIL wide_xor: got vld=%b y=%h yz=%b, expected vld=1 y=0000ff yz=110",
               w_out_valid, w_y, w_y_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (w_out_valid !== 1'b0 || w_y !== 24'h0) begin
      errors++;
      $display("FAIL wide_drain: got vld=%b y=%h, expected vld=0 y=0", w_out_valid, w_y);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_array_pipe.md
GATE_ARRAY_PIPE -- requirements
Module: gate_array_pipe

Interface
REQ-001 Parameter CHANNELS, default 4, SHALL set the number of independent two-input gates.
REQ-002 Parameter WIDTH, default 1, SHALL set the bit width of each gate's operands and result.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1, SHALL mark that a, b and op carry a request.
REQ-006 Port in_ready, output, 1, SHALL mark that the block can accept a request this cycle.
REQ-007 Port op, input, 3, SHALL select the gate function for all channels of the request.
REQ-008 Port a, input, CHANNELS*WIDTH, SHALL carry operand A; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port b, input, CHANNELS*WIDTH, SHALL carry operand B, packed as a.
REQ-010 Port out_valid, output, 1, SHALL mark that y and y_zero hold a result.
REQ-011 Port out_ready, input, 1, SHALL mark that the consumer takes the result this cycle.
REQ-012 Port y, output, CHANNELS*WIDTH, SHALL carry the result, packed as a.
REQ-013 Port y_zero, output, CHANNELS, SHALL flag bit k high when channel k's result is all zeros.

Function
REQ-014 Decode SHALL be: op 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 pass A, 7 NOT A.
- All bitwise.
- Each channel computes independently.
REQ-015 Accept SHALL occur on cycles with in_valid && in_ready; release SHALL occur on cycles with out_valid && out_ready.
REQ-016 Each result SHALL be computed from the a, b and op sampled at accept and stored in a 2-entry in-order buffer.
REQ-017 Buffer states SHALL be EMPTY, ONE and FULL, with these transitions:
- Accept only: EMPTY->ONE, ONE->FULL.
- Release only: FULL->ONE, ONE->EMPTY.
- Accept and release together in ONE: stays ONE.
REQ-018 in_ready SHALL equal (state != FULL) and SHALL be driven from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (state != EMPTY).
REQ-020 Latency SHALL be 1 cycle: a request accepted at edge N appears with out_valid high after edge N, when the buffer was EMPTY.
REQ-021 While out_valid is high and out_ready is low, y and y_zero SHALL hold stable.
REQ-022 Results SHALL leave in acceptance order.
- No drop: a result leaves only on release.
- No duplication: each result leaves exactly once.
REQ-023 When FULL, in_valid SHALL be ignored. A release in the same cycle frees a slot for the next cycle only.
REQ-024 When EMPTY, out_ready SHALL have no effect.
REQ-025 y and y_zero SHALL be 0 whenever out_valid is low.
REQ-026 With in_valid and out_ready held high from ONE, throughput SHALL be one result per cycle.

Reset
REQ-027 Asserting rst SHALL immediately force the following, regardless of clk:
- State EMPTY.
- in_ready 1, out_valid 0.
- y 0, y_zero 0.
- txn_count 0, when present.
REQ-028 Reset mid-transfer SHALL discard all buffered results. No result SHALL appear after rst deasserts until a new accept.
REQ-029 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-030 With macro GATE_ARRAY_PIPE_STATS_EN defined, the block SHALL add output port txn_count, 16 bits.
- Increments by 1 on each release.
- Saturates at 16'hFFFF.
REQ-031 Without GATE_ARRAY_PIPE_STATS_EN, port txn_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Bench SHALL cover these directed scenarios (defaults CHANNELS=4, WIDTH=1):
- Reset, then op=0, a=4'b1100, b=4'b1010, out_ready=1 -> next cycle out_valid=1, y=4'b1000, y_zero=4'b0111.
- op 1..7 each with a=4'b1100, b=4'b1010 -> y=1110, 0110, 0111, 0001, 1001, 1100, 0011.
- out_ready=0, three back-to-back requests -> in_ready low after two accepts, third held off. Then out_ready=1 -> results in order, y stable while stalled.
- out_ready=1, in_valid high 10 cycles -> 10 results, one per cycle, txn_count=10 when GATE_ARRAY_PIPE_STATS_EN is defined.
- rst pulsed between clock edges with buffer FULL -> out_valid=0, y=0, in_ready=1 immediately; no stale result after release.
- CHANNELS=3, WIDTH=8, op=2, a=24'hFF00AA, b=24'hFF0055 -> y=24'h0000FF, y_zero=3'b110.
